// File: rtl/spi_req_sequencer.sv
// Round-robin sequencer sharing one spi_top master among NREQ requesters.
// Optional busy-poll timeout abort is enabled by defining SPI_SEQ_TIMEOUT_EN.
`ifndef SPI_CTRL
`define SPI_CTRL   2'd0
`endif
`ifndef SPI_CONFIG
`define SPI_CONFIG 2'd1
`endif
`ifndef SPI_SSELEC
`define SPI_SSELEC 2'd2
`endif
`ifndef SPI_BUFFER
`define SPI_BUFFER 2'd3
`endif

module spi_req_sequencer #(
  parameter int NREQ    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   Req,
  input  logic [2*NREQ-1:0] ReqMode,
  input  logic [4*NREQ-1:0] ReqPre,
  input  logic [3*NREQ-1:0] ReqSlave,
  input  logic [8*NREQ-1:0] ReqTx,
  output logic [NREQ-1:0]   Grant,
  output logic [NREQ-1:0]   Ack,
  output logic [7:0]        RxData,
  output logic              Err,
  output logic [1:0]        Addr,
  output logic              Wr,
  output logic [7:0]        DataWr,
  input  logic [7:0]        DataRd
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ARB, S_WCFG, S_WSEL, S_WBUF,
    S_GAPW, S_POLL, S_RDBK, S_DESEL, S_DONE
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t          state, state_n;
  logic [2:0]      ptr, ptr_n;
  logic [2:0]      slave_q, slave_n;
  logic [7:0]      tx_q, tx_n;
  logic [7:0]      gap_cnt, gap_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic [7:0]      rx_n, dwr_n;
  logic [1:0]      addr_n;
  logic            wr_n;

  // round-robin pick: first request at or after ptr, wrapping
  logic [2:0]      win;
  logic [NREQ-1:0] win_oh;
  logic            found;
  int              idx;

  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && Req[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
    win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [9:0] TMO = 10'(TIMEOUT);
  logic [9:0] tcnt, tcnt_n;
  logic       tflag, tflag_n, err_n;
`endif

  // registered outputs: each state's decisions become visible the following cycle
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    slave_n = slave_q;
    tx_n    = tx_q;
    gap_n   = gap_cnt;
    grant_n = Grant;
    ack_n   = '0;
    rx_n    = RxData;
    wr_n    = 1'b0;
    addr_n  = `SPI_CTRL;
    dwr_n   = DataWr;
`ifdef SPI_SEQ_TIMEOUT_EN
    err_n   = 1'b0;
    tcnt_n  = tcnt;
    tflag_n = tflag;
`endif
    case (state)
      S_INIT: begin
        wr_n    = 1'b1;
        dwr_n   = 8'h01;
        state_n = S_IDLE;
      end
      S_IDLE: if (|Req) state_n = S_ARB;
      S_ARB: begin
        if (found) begin
          grant_n = win_oh;
          ptr_n   = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
          slave_n = ReqSlave[3*win +: 3];
          tx_n    = ReqTx[8*win +: 8];
          wr_n    = 1'b1;
          addr_n  = `SPI_CONFIG;
          dwr_n   = {2'b00, ReqMode[2*win +: 2], ReqPre[4*win +: 4]};
          state_n = S_WCFG;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WCFG: begin
        wr_n    = 1'b1;
        addr_n  = `SPI_SSELEC;
        dwr_n   = ~(8'h01 << slave_q);
        state_n = S_WSEL;
      end
      S_WSEL: begin
        wr_n    = 1'b1;
        addr_n  = `SPI_BUFFER;
        dwr_n   = tx_q;
        state_n = S_WBUF;
      end
      S_WBUF: begin
        gap_n   = 8'd0;
        state_n = S_GAPW;
      end
      S_GAPW: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
          tcnt_n  = 10'd0;
`endif
        end else begin
          gap_n = gap_cnt + 8'd1;
        end
      end
      S_POLL: begin
        if (!DataRd[7]) begin
          addr_n  = `SPI_BUFFER;
          state_n = S_RDBK;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (tcnt == TMO) begin
          wr_n    = 1'b1;
          addr_n  = `SPI_SSELEC;
          dwr_n   = 8'hFF;
          tflag_n = 1'b1;
          state_n = S_DESEL;
        end else begin
          tcnt_n = tcnt + 10'd1;
        end
`endif
      end
      S_RDBK: begin
        rx_n    = DataRd;
        wr_n    = 1'b1;
        addr_n  = `SPI_SSELEC;
        dwr_n   = 8'hFF;
        state_n = S_DESEL;
      end
      S_DESEL: begin
        ack_n   = Grant;
`ifdef SPI_SEQ_TIMEOUT_EN
        err_n   = tflag;
`endif
        state_n = S_DONE;
      end
      S_DONE: begin
        grant_n = '0;
`ifdef SPI_SEQ_TIMEOUT_EN
        tflag_n = 1'b0;
`endif
        state_n = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_INIT;
      ptr     <= 3'd0;
      slave_q <= 3'd0;
      tx_q    <= 8'h00;
      gap_cnt <= 8'd0;
      Grant   <= '0;
      Ack     <= '0;
      RxData  <= 8'h00;
      Wr      <= 1'b0;
      Addr    <= `SPI_CTRL;
      DataWr  <= 8'h00;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      slave_q <= slave_n;
      tx_q    <= tx_n;
      gap_cnt <= gap_n;
      Grant   <= grant_n;
      Ack     <= ack_n;
      RxData  <= rx_n;
      Wr      <= wr_n;
      Addr    <= addr_n;
      DataWr  <= dwr_n;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tcnt  <= 10'd0;
      tflag <= 1'b0;
      Err   <= 1'b0;
    end else begin
      tcnt  <= tcnt_n;
      tflag <= tflag_n;
      Err   <= err_n;
    end
  end
`else
  assign Err = 1'b0;
`endif

endmodule
